// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard control for a 5-stage pipeline. Drives the hold (EN)
//                and clear (CLR) inputs of the stage registers. Detects
//                load-use and branch-compare hazards, selects the bypass
//                paths, and tracks the multi-cycle mul/div unit with a small
//                FSM. While that FSM is busy, any instruction that depends on
//                mul/div is held in Decode.
//  Ports       : clk_i, clr_i               clock, synchronous active-high reset
//                rs/rt_{d,e}_i              source registers, Decode/Execute
//                write_reg_{e,m,w}_i        destination register per stage
//                reg_write_{e,m,w}_i        destination write enable per stage
//                mem_to_reg_{e,m}_i         stage holds a load
//                branch_d_i, jump_d_i,
//                pc_src_d_i                 control-flow redirect in Decode
//                md_start_e_i, md_use_d_i   mul/div issue / mul/div consumer
//                stall_f_o, stall_d_o       hold Fetch/Decode
//                flush_d_o, flush_e_o       clear Decode/Execute
//                fwd_a_d_o, fwd_b_d_o       Decode compare bypass from Memory
//                fwd_a_e_o, fwd_b_e_o       ALU operand select (00 RF, 01 WB, 10 MEM)
//                md_busy_o, md_done_o       mul/div in progress / result-ready pulse
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
   parameter int R      = 5,
   parameter int MD_LAT = 4
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic [R-1:0] rs_d_i,
   input  logic [R-1:0] rt_d_i,
   input  logic [R-1:0] rs_e_i,
   input  logic [R-1:0] rt_e_i,
   input  logic [R-1:0] write_reg_e_i,
   input  logic [R-1:0] write_reg_m_i,
   input  logic [R-1:0] write_reg_w_i,
   input  logic         reg_write_e_i,
   input  logic         reg_write_m_i,
   input  logic         reg_write_w_i,
   input  logic         mem_to_reg_e_i,
   input  logic         mem_to_reg_m_i,
   input  logic         branch_d_i,
   input  logic         jump_d_i,
   input  logic         pc_src_d_i,
   input  logic         md_start_e_i,
   input  logic         md_use_d_i,
   output logic         stall_f_o,
   output logic         stall_d_o,
   output logic         flush_d_o,
   output logic         flush_e_o,
   output logic         fwd_a_d_o,
   output logic         fwd_b_d_o,
   output logic [1:0]   fwd_a_e_o,
   output logic [1:0]   fwd_b_e_o,
   output logic         md_busy_o,
   output logic         md_done_o
);

   localparam int           CW      = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
   localparam logic [CW-1:0] C_RELOAD = CW'(MD_LAT - 1);
   localparam logic [CW-1:0] C_ONE    = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } md_state_t;

   md_state_t     state_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic          done_q;

   // Register $0 is hard-wired to zero, so it never creates a dependence.
   logic w_m_valid, w_w_valid, w_e_valid;
   assign w_m_valid = reg_write_m_i & (write_reg_m_i != '0);
   assign w_w_valid = reg_write_w_i & (write_reg_w_i != '0);
   assign w_e_valid = reg_write_e_i & (write_reg_e_i != '0);

   logic [1:0] w_fwd_a_e, w_fwd_b_e;
   always_comb begin
      w_fwd_a_e = 2'b00;
      if (w_m_valid && write_reg_m_i == rs_e_i)      w_fwd_a_e = 2'b10;
      else if (w_w_valid && write_reg_w_i == rs_e_i) w_fwd_a_e = 2'b01;
      w_fwd_b_e = 2'b00;
      if (w_m_valid && write_reg_m_i == rt_e_i)      w_fwd_b_e = 2'b10;
      else if (w_w_valid && write_reg_w_i == rt_e_i) w_fwd_b_e = 2'b01;
   end

   logic w_lwstall, w_brstall, w_mdstall, w_stall;
   assign w_lwstall = mem_to_reg_e_i & (rt_e_i != '0) &
                      ((rt_e_i == rs_d_i) | (rt_e_i == rt_d_i));
   // A load in Memory cannot be bypassed into the Decode comparator yet.
   assign w_brstall = branch_d_i &
                      ((w_e_valid & ((write_reg_e_i == rs_d_i) | (write_reg_e_i == rt_d_i))) |
                       (mem_to_reg_m_i & (write_reg_m_i != '0) &
                        ((write_reg_m_i == rs_d_i) | (write_reg_m_i == rt_d_i))));
   // Issuing mul/div this cycle already blocks a consumer sitting in Decode.
   assign w_mdstall = md_use_d_i & (busy_q | md_start_e_i);
   assign w_stall   = w_lwstall | w_brstall | w_mdstall;

   // Every output is forced low while reset is asserted.
   assign stall_f_o = w_stall & ~clr_i;
   assign stall_d_o = w_stall & ~clr_i;
   assign flush_e_o = w_stall & ~clr_i;
   // A stalled redirect is dropped here and repeats when Decode is re-presented.
   assign flush_d_o = (pc_src_d_i | jump_d_i) & ~w_stall & ~clr_i;
   assign fwd_a_d_o = w_m_valid & (write_reg_m_i == rs_d_i) & ~clr_i;
   assign fwd_b_d_o = w_m_valid & (write_reg_m_i == rt_d_i) & ~clr_i;
   assign fwd_a_e_o = clr_i ? 2'b00 : w_fwd_a_e;
   assign fwd_b_e_o = clr_i ? 2'b00 : w_fwd_b_e;
   assign md_busy_o = busy_q & ~clr_i;
   assign md_done_o = done_q & ~clr_i;

   // busy_q/done_q mirror state_q == BUSY/DONE as registered outputs.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (md_start_e_i) begin
                  state_q <= S_BUSY;
                  cnt_q   <= C_RELOAD;
                  busy_q  <= 1'b1;
               end
            end
            S_BUSY: begin
               if (md_start_e_i) begin
                  // Overlapping issue: abandon the old op silently and restart.
                  cnt_q  <= C_RELOAD;
                  busy_q <= 1'b1;
               end else if (cnt_q == C_ONE) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q  <= cnt_q - C_ONE;
                  busy_q <= 1'b1;
               end
            end
            S_DONE: begin
               if (md_start_e_i) begin
                  state_q <= S_BUSY;
                  cnt_q   <= C_RELOAD;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl. Uses a few directed
//                sequences followed by random traffic, all compared against
//                a behavioural reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int R      = 5;
   localparam int MD_LAT = 4;

   logic         clk;
   logic         clr;
   logic [R-1:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
   logic         rw_e, rw_m, rw_w, mtr_e, mtr_m;
   logic         branch_d, jump_d, pc_src_d, md_start_e, md_use_d;
   logic         stall_f, stall_d, flush_d, flush_e, fwd_a_d, fwd_b_d;
   logic [1:0]   fwd_a_e, fwd_b_e;
   logic         md_busy, md_done;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference mul/div tracker: cycles left until the result is ready.
   bit m_active = 0;
   bit m_done   = 0;
   int m_rem    = 0;

   hazard_ctrl #(.R(R), .MD_LAT(MD_LAT)) dut (
      .clk_i          (clk),
      .clr_i          (clr),
      .rs_d_i         (rs_d),
      .rt_d_i         (rt_d),
      .rs_e_i         (rs_e),
      .rt_e_i         (rt_e),
      .write_reg_e_i  (wr_e),
      .write_reg_m_i  (wr_m),
      .write_reg_w_i  (wr_w),
      .reg_write_e_i  (rw_e),
      .reg_write_m_i  (rw_m),
      .reg_write_w_i  (rw_w),
      .mem_to_reg_e_i (mtr_e),
      .mem_to_reg_m_i (mtr_m),
      .branch_d_i     (branch_d),
      .jump_d_i       (jump_d),
      .pc_src_d_i     (pc_src_d),
      .md_start_e_i   (md_start_e),
      .md_use_d_i     (md_use_d),
      .stall_f_o      (stall_f),
      .stall_d_o      (stall_d),
      .flush_d_o      (flush_d),
      .flush_e_o      (flush_e),
      .fwd_a_d_o      (fwd_a_d),
      .fwd_b_d_o      (fwd_b_d),
      .fwd_a_e_o      (fwd_a_e),
      .fwd_b_e_o      (fwd_b_e),
      .md_busy_o      (md_busy),
      .md_done_o      (md_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [1:0] ref_fwd_e(input logic [R-1:0] src);
      if (rw_m && wr_m != 0 && wr_m == src) return 2'b10;
      if (rw_w && wr_w != 0 && wr_w == src) return 2'b01;
      return 2'b00;
   endfunction

   task automatic compare_all;
      bit lw, br, md, st, hit_e, hit_m;
      lw    = mtr_e && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d);
      hit_e = rw_e && wr_e != 0 && (wr_e == rs_d || wr_e == rt_d);
      hit_m = mtr_m && wr_m != 0 && (wr_m == rs_d || wr_m == rt_d);
      br    = branch_d && (hit_e || hit_m);
      md    = md_use_d && (m_active || md_start_e);
      st    = (lw || br || md) && !clr;
      check_eq("stall_f", 32'(stall_f), 32'(st));
      check_eq("stall_d", 32'(stall_d), 32'(st));
      check_eq("flush_e", 32'(flush_e), 32'(st));
      check_eq("flush_d", 32'(flush_d), 32'((pc_src_d || jump_d) && !st && !clr));
      check_eq("fwd_a_d", 32'(fwd_a_d), 32'(!clr && rw_m && wr_m != 0 && wr_m == rs_d));
      check_eq("fwd_b_d", 32'(fwd_b_d), 32'(!clr && rw_m && wr_m != 0 && wr_m == rt_d));
      check_eq("fwd_a_e", 32'(fwd_a_e), clr ? 32'd0 : 32'(ref_fwd_e(rs_e)));
      check_eq("fwd_b_e", 32'(fwd_b_e), clr ? 32'd0 : 32'(ref_fwd_e(rt_e)));
      check_eq("md_busy", 32'(md_busy), 32'(m_active && !clr));
      check_eq("md_done", 32'(md_done), 32'(m_done && !clr));
   endtask

   task automatic model_edge;
      if (clr) begin
         m_active = 0; m_done = 0; m_rem = 0;
      end else if (md_start_e) begin
         m_active = 1; m_done = 0; m_rem = MD_LAT - 1;
      end else if (m_active) begin
         m_rem--;
         if (m_rem == 0) begin m_active = 0; m_done = 1; end
      end else begin
         m_done = 0;
      end
   endtask

   // Inputs are already driven; check mid-cycle, then advance past the edge.
   task automatic cycle;
      @(negedge clk);
      compare_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic quiet;
      {rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w} = '0;
      {rw_e, rw_m, rw_w, mtr_e, mtr_m} = '0;
      {branch_d, jump_d, pc_src_d, md_start_e, md_use_d} = '0;
   endtask

   initial begin
      quiet();
      clr = 1'b1;
      #1;
      repeat (2) cycle();
      clr = 1'b0;

      // Load-use: lw $2 in Execute, Decode reads $2.
      mtr_e = 1; rt_e = 2; rs_d = 2; cycle();
      quiet(); cycle();

      // Memory beats Writeback on the ALU bypass; $0 never forwards.
      rw_m = 1; wr_m = 5; rw_w = 1; wr_w = 5; rs_e = 5; cycle();
      rs_e = 0; cycle();
      quiet();

      // Branch compare dependence, then bypass from Memory plus taken branch.
      branch_d = 1; rs_d = 3; rw_e = 1; wr_e = 3; cycle();
      rw_e = 0; wr_e = 0; rw_m = 1; wr_m = 3; pc_src_d = 1; cycle();
      quiet();

      // Mul/div with a dependent instruction waiting in Decode.
      md_start_e = 1; md_use_d = 1; cycle();
      md_start_e = 0; repeat (MD_LAT + 2) cycle();
      quiet();

      // Reset in the middle of a mul/div.
      md_start_e = 1; cycle();
      md_start_e = 0; cycle();
      clr = 1; jump_d = 1; rw_m = 1; wr_m = 4; rs_e = 4; cycle();
      clr = 0; quiet(); repeat (MD_LAT + 2) cycle();

      // Jump blocked by a load-use stall, then re-presented cleanly.
      jump_d = 1; mtr_e = 1; rt_e = 7; rt_d = 7; cycle();
      mtr_e = 0; cycle();
      quiet();

      // Random traffic with a narrow register range so hazards collide often.
      for (int i = 0; i < 3000; i++) begin
         rs_d = R'($urandom_range(0, 3)); rt_d = R'($urandom_range(0, 3));
         rs_e = R'($urandom_range(0, 3)); rt_e = R'($urandom_range(0, 3));
         wr_e = R'($urandom_range(0, 3)); wr_m = R'($urandom_range(0, 3));
         wr_w = R'($urandom_range(0, 3));
         rw_e = 1'($urandom); rw_m = 1'($urandom); rw_w = 1'($urandom);
         mtr_e = ($urandom_range(0, 3) == 0); mtr_m = ($urandom_range(0, 3) == 0);
         branch_d = 1'($urandom); jump_d = ($urandom_range(0, 3) == 0);
         pc_src_d = ($urandom_range(0, 3) == 0);
         md_start_e = ($urandom_range(0, 9) == 0);
         md_use_d = 1'($urandom);
         clr = ($urandom_range(0, 59) == 0);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
